// File: rtl/arm_mem_responder.sv
// Memory-side responder for the CPU MFA/MFC handshake.
// Byte-addressed storage with programmable wait states.
module arm_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              READ_WRITE,
    input  logic              WORD_BYTE,
    input  logic [ADDR_W-1:0] MEMADD,
    input  logic [31:0]       MEMDAT_IN,
    output logic [31:0]       MEMDAT,
    output logic              MFC,
    output logic              MEMLOAD,
    output logic              ERR
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic              wb;
    logic [31:0]       wdata;
    logic [7:0]        mem [DEPTH];

    logic              take;
    logic              access;
    logic              misalign;
    logic              wr_word;
    logic              wr_byte;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] b0;
    logic [ADDR_W-1:0] b1;
    logic [ADDR_W-1:0] b2;
    logic [ADDR_W-1:0] b3;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (MFA) state_nxt = BUSY;
            BUSY: begin
                if (!MFA) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: if (!MFA) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word lanes: aligned words never straddle the top of storage
    always_comb begin
        b0       = {addr[ADDR_W-1:2], 2'd0};
        b1       = {addr[ADDR_W-1:2], 2'd1};
        b2       = {addr[ADDR_W-1:2], 2'd2};
        b3       = {addr[ADDR_W-1:2], 2'd3};
        take     = (state == IDLE) && MFA;
        access   = (state == BUSY) && MFA && (cnt == 4'd0);
        misalign = wb && (addr[1:0] != 2'd0);
        wr_word  = access && !rw && wb && !misalign;
        wr_byte  = access && !rw && !wb;
        if (wb) begin
            rdata = {mem[b3], mem[b2], mem[b1], mem[b0]};
        end else begin
            rdata = {24'd0, mem[addr]};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt     <= 4'd0;
            addr    <= '0;
            rw      <= 1'b0;
            wb      <= 1'b0;
            wdata   <= 32'd0;
            MFC     <= 1'b0;
            MEMLOAD <= 1'b0;
            ERR     <= 1'b0;
            MEMDAT  <= 32'd0;
        end else begin
            if (take) begin
                addr  <= MEMADD;
                rw    <= READ_WRITE;
                wb    <= WORD_BYTE;
                wdata <= MEMDAT_IN;
                cnt   <= WAIT_INIT;
            end else if ((state == BUSY) && MFA && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                MFC     <= 1'b1;
                MEMLOAD <= rw;
                ERR     <= misalign;
                if (misalign) begin
                    MEMDAT <= 32'd0;
                end else if (rw) begin
                    MEMDAT <= rdata;
                end
            end else if ((state == DONE) && !MFA) begin
                MFC     <= 1'b0;
                MEMLOAD <= 1'b0;
                ERR     <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge Clk) begin
        if (wr_word) begin
            mem[b0] <= wdata[7:0];
            mem[b1] <= wdata[15:8];
            mem[b2] <= wdata[23:16];
            mem[b3] <= wdata[31:24];
        end else if (wr_byte) begin
            mem[addr] <= wdata[7:0];
        end
    end

endmodule

// File: tb/tb_arm_mem_responder.sv
// Directed bench for arm_mem_responder with a
// transaction-level reference model and per-cycle compare.
module tb_arm_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mfa = 1'b0;
    logic        rw_i = 1'b0;
    logic        wb_i = 1'b0;
    logic [7:0]  add_i = 8'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] memdat;
    logic        mfc;
    logic        memload;
    logic        err;

    int total = 0;
    int bad = 0;
    bit started = 0;

    arm_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
        .Clk(clk),
        .Reset(rst_n),
        .MFA(mfa),
        .READ_WRITE(rw_i),
        .WORD_BYTE(wb_i),
        .MEMADD(add_i),
        .MEMDAT_IN(din),
        .MEMDAT(memdat),
        .MFC(mfc),
        .MEMLOAD(memload),
        .ERR(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts edges since the request was sampled
    int          phase = 0;
    logic        m_rw;
    logic        m_wb;
    logic [7:0]  m_a;
    logic [31:0] m_d;
    logic [7:0]  mm [256];
    logic        e_mfc = 0;
    logic        e_ld = 0;
    logic        e_err = 0;
    logic [31:0] e_dat = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            e_mfc = 0;
            e_ld  = 0;
            e_err = 0;
            e_dat = 0;
        end else if (e_mfc) begin
            if (!mfa) begin
                e_mfc = 0;
                e_ld  = 0;
                e_err = 0;
                phase = 0;
            end
        end else if (phase == 0) begin
            if (mfa) begin
                m_rw  = rw_i;
                m_wb  = wb_i;
                m_a   = add_i;
                m_d   = din;
                phase = 1;
            end
        end else if (!mfa) begin
            phase = 0;
        end else if (phase < W + 1) begin
            phase++;
        end else begin
            e_mfc = 1;
            e_ld  = m_rw;
            if (m_wb && (m_a % 4 != 0)) begin
                e_err = 1;
                e_dat = 0;
            end else if (m_rw) begin
                e_dat = 0;
                for (int k = 0; k < (m_wb ? 4 : 1); k++)
                    e_dat = e_dat + (32'(mm[8'(m_a + k)]) << (8 * k));
            end else begin
                for (int k = 0; k < (m_wb ? 4 : 1); k++)
                    mm[8'(m_a + k)] = 8'((m_d >> (8 * k)) & 32'hFF);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("mfc", 32'(mfc), 32'(e_mfc));
            chk("memload", 32'(memload), 32'(e_ld));
            chk("err", 32'(err), 32'(e_err));
            chk("memdat", memdat, e_dat);
        end
    end

    // Issue one request starting at a falling edge; ends at a falling edge
    task automatic req(input bit rw, input bit wb, input logic [7:0] a,
                       input logic [31:0] d, input int hold,
                       input bit chk_dat, input logic [31:0] exp_dat,
                       input bit exp_err);
        int n;
        bit got;
        mfa   = 1'b1;
        rw_i  = rw;
        wb_i  = wb;
        add_i = a;
        din   = d;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                rw_i  = ~rw;
                wb_i  = ~wb;
                add_i = a ^ 8'h5A;
                din   = ~d;
            end
            if (mfc) got = 1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout addr=%h got=no_mfc want=mfc", a);
        end else begin
            chk("latency", 32'(n), 32'(W + 2));
            chk("err_lit", 32'(err), 32'(exp_err));
            chk("memload_lit", 32'(memload), 32'(rw));
            if (chk_dat) chk("data_lit", memdat, exp_dat);
            repeat (hold) begin
                @(negedge clk);
                chk("mfc_hold", 32'(mfc), 32'd1);
            end
        end
        mfa = 1'b0;
        @(negedge clk);
        chk("mfc_drop", 32'(mfc), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_mfc", 32'(mfc), 32'd0);
        chk("rst_dat", memdat, 32'd0);
        rst_n = 1'b1;
        started = 1;
        @(negedge clk);
        // Seed locations that are read back later
        req(0, 1, 8'h20, 32'hCAFEF00D, 0, 0, 0, 0);
        req(0, 1, 8'h30, 32'h0BADF00D, 0, 0, 0, 0);
        // Word write then read
        req(0, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        req(1, 1, 8'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0);
        // Byte read, byte write, merged word read
        req(1, 0, 8'h11, 32'h0, 0, 1, 32'h000000BE, 0);
        req(0, 0, 8'h13, 32'hFFFFFF55, 0, 0, 0, 0);
        req(1, 1, 8'h10, 32'h0, 0, 1, 32'h55ADBEEF, 0);
        // Misaligned word write and read
        req(0, 1, 8'h22, 32'h11223344, 0, 0, 0, 1);
        req(1, 1, 8'h20, 32'h0, 0, 1, 32'hCAFEF00D, 0);
        req(1, 1, 8'h21, 32'h0, 0, 1, 32'h0, 1);
        // Top byte of storage
        req(0, 0, 8'hFF, 32'h000000A5, 0, 0, 0, 0);
        req(1, 0, 8'hFF, 32'h0, 0, 1, 32'h000000A5, 0);
        // Aborted word write
        mfa   = 1'b1;
        rw_i  = 1'b0;
        wb_i  = 1'b1;
        add_i = 8'h30;
        din   = 32'h12345678;
        repeat (2) @(negedge clk);
        mfa = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_mfc", 32'(mfc), 32'd0);
        end
        req(1, 1, 8'h30, 32'h0, 0, 1, 32'h0BADF00D, 0);
        // Long hold in DONE, then immediate next request
        req(1, 0, 8'h10, 32'h0, 5, 1, 32'h000000EF, 0);
        req(1, 1, 8'h30, 32'h0, 0, 1, 32'h0BADF00D, 0);
        // Reset in the middle of a write
        mfa   = 1'b1;
        rw_i  = 1'b0;
        wb_i  = 1'b1;
        add_i = 8'h20;
        din   = 32'h11111111;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        mfa = 1'b0;
        #1;
        chk("rst_mid_mfc", 32'(mfc), 32'd0);
        chk("rst_mid_ld", 32'(memload), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_dat", memdat, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        req(1, 1, 8'h20, 32'h0, 0, 1, 32'hCAFEF00D, 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
